// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//    Round-robin arbiter that shares one FIFO write port among NUM_REQ
//    requesters. A winner owns the port for up to MAX_BURST words, then the
//    port returns to IDLE for one cycle before the next arbitration.
//
// Ports
//    clk         system clock, rising edge
//    rst_n       asynchronous active-low reset
//    req         per-requester write request (held while data is available)
//    req_data    packed requester words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//    fifo_full   FIFO full flag (clk domain)
//    fifo_winc   FIFO write enable
//    fifo_wdata  FIFO write data (owner's word in BURST, zero otherwise)
//    grant       registered one-hot owner, zero when idle
//    ack         one-hot pulse to the owner when its word is written
//    busy        high while a burst is in progress
//    burst_cnt   words written in the current grant
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 4,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic                          fifo_full,
   output logic                          fifo_winc,
   output logic [DATA_WIDTH-1:0]         fifo_wdata,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            ack,
   output logic                          busy,
   output logic [3:0]                    burst_cnt
);

   localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {IDLE, BURST} state_t;

   state_t              state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [OW-1:0]       owner_q, owner_d;
   logic [OW-1:0]       last_owner_q, last_owner_d;
   logic [3:0]          burst_cnt_q, burst_cnt_d;

   logic                in_burst;
   logic                owner_req;
   logic                pick_found;
   logic [OW-1:0]       pick_idx;

   assign in_burst = (state_q == BURST);

   // Owner's request and data are selected through the one-hot grant, which
   // is all zero in IDLE, so both fall to zero without an extra state term.
   always_comb begin
      owner_req  = 1'b0;
      fifo_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) begin
            owner_req  = req[i];
            fifo_wdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign fifo_winc = in_burst & owner_req & ~fifo_full;
   assign ack       = grant_q & {NUM_REQ{fifo_winc}};
   assign grant     = grant_q;
   assign busy      = in_burst;
   assign burst_cnt = burst_cnt_q;

   // Round-robin scan starting one past the previous owner, with wrap.
   always_comb begin
      int idx;
      pick_found = 1'b0;
      pick_idx   = '0;
      idx        = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = int'(last_owner_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!pick_found && req[OW'(idx)]) begin
            pick_found = 1'b1;
            pick_idx   = OW'(idx);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      burst_cnt_d  = burst_cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               owner_d           = pick_idx;
               burst_cnt_d       = '0;
               state_d           = BURST;
            end
         end
         BURST: begin
            if (fifo_winc) burst_cnt_d = burst_cnt_q + 4'd1;
            // A full FIFO with req still high is a stall: nothing changes.
            if ((fifo_winc && (burst_cnt_q == 4'(MAX_BURST - 1))) || !owner_req) begin
               state_d      = IDLE;
               grant_d      = '0;
               last_owner_d = owner_q;
               burst_cnt_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         owner_q      <= '0;
         last_owner_q <= OW'(NUM_REQ - 1);
         burst_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=4, MAX_BURST=4).
module tb_fifo_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] req_data;
   logic        fifo_full;
   logic        fifo_winc;
   logic [3:0]  fifo_wdata;
   logic [3:0]  grant;
   logic [3:0]  ack;
   logic        busy;
   logic [3:0]  burst_cnt;

   int total = 0;
   int bad   = 0;

   fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4), .MAX_BURST(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .req_data   (req_data),
      .fifo_full  (fifo_full),
      .fifo_winc  (fifo_winc),
      .fifo_wdata (fifo_wdata),
      .grant      (grant),
      .ack        (ack),
      .busy       (busy),
      .burst_cnt  (burst_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Full output snapshot: grant, busy, winc, wdata, ack, burst_cnt.
   task automatic chk_all(input string tag, input logic [3:0] g, input logic b,
                          input logic w, input logic [3:0] d, input logic [3:0] a,
                          input logic [3:0] c);
      chk({tag, ".grant"}, 16'(grant), 16'(g));
      chk({tag, ".busy"},  16'(busy), 16'(b));
      chk({tag, ".winc"},  16'(fifo_winc), 16'(w));
      chk({tag, ".wdata"}, 16'(fifo_wdata), 16'(d));
      chk({tag, ".ack"},   16'(ack), 16'(a));
      chk({tag, ".cnt"},   16'(burst_cnt), 16'(c));
   endtask

   // Invariants sampled mid-cycle while inputs are stable.
   always @(negedge clk) begin
      total++;
      assert ($onehot0(grant) && $onehot0(ack) && !(fifo_winc && fifo_full)) else begin
         bad++;
         $error("FAIL invariant observed grant=%b ack=%b winc=%b full=%b required onehot0/no-write-when-full",
                grant, ack, fifo_winc, fifo_full);
      end
   end

   logic [3:0] rr_g [5];
   logic [3:0] rr_d [5];

   initial begin
      rr_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rr_d = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};

      rst_n     = 1'b0;
      req       = 4'b0000;
      req_data  = 16'hDCBA;   // r0=A r1=B r2=C r3=D
      fifo_full = 1'b0;

      // Reset state
      cyc();
      chk_all("reset", 4'b0000, 1'b0, 1'b0, 4'h0, 4'b0000, 4'd0);
      req = 4'b1111;
      #1;
      chk_all("reset_req", 4'b0000, 1'b0, 1'b0, 4'h0, 4'b0000, 4'd0);
      cyc();

      // Round robin from requester 0 with all requesting
      rst_n = 1'b1;
      #1;
      chk_all("rel_idle", 4'b0000, 1'b0, 1'b0, 4'h0, 4'b0000, 4'd0);
      cyc();
      for (int g = 0; g < 5; g++) begin
         for (int k = 0; k < 4; k++) begin
            chk_all($sformatf("rr%0d_w%0d", g, k), rr_g[g], 1'b1, 1'b1, rr_d[g], rr_g[g], 4'(k));
            cyc();
         end
         chk_all($sformatf("rr%0d_bubble", g), 4'b0000, 1'b0, 1'b0, 4'h0, 4'b0000, 4'd0);
         if (g == 4) req = 4'b0000;
         cyc();
      end
      chk_all("idle_noreq", 4'b0000, 1'b0, 1'b0, 4'h0, 4'b0000, 4'd0);

      // Single requester: four writes, bubble, re-grant
      req = 4'b0001;
      #1;
      chk_all("single_req_cycle", 4'b0000, 1'b0, 1'b0, 4'h0, 4'b0000, 4'd0);
      cyc();
      for (int k = 0; k < 4; k++) begin
         chk_all($sformatf("single_w%0d", k), 4'b0001, 1'b1, 1'b1, 4'hA, 4'b0001, 4'(k));
         cyc();
      end
      chk_all("single_bubble", 4'b0000, 1'b0, 1'b0, 4'h0, 4'b0000, 4'd0);
      cyc();
      chk_all("single_regrant", 4'b0001, 1'b1, 1'b1, 4'hA, 4'b0001, 4'd0);
      req = 4'b0000;
      #1;
      chk_all("single_drop", 4'b0001, 1'b1, 1'b0, 4'hA, 4'b0000, 4'd0);
      cyc();
      chk_all("single_end", 4'b0000, 1'b0, 1'b0, 4'h0, 4'b0000, 4'd0);

      // Full stall on requester 1 after two writes
      req = 4'b0010;
      cyc();
      chk_all("stall_w0", 4'b0010, 1'b1, 1'b1, 4'hB, 4'b0010, 4'd0);
      cyc();
      chk_all("stall_w1", 4'b0010, 1'b1, 1'b1, 4'hB, 4'b0010, 4'd1);
      cyc();
      fifo_full = 1'b1;
      #1;
      for (int s = 0; s < 3; s++) begin
         chk_all($sformatf("stall_s%0d", s), 4'b0010, 1'b1, 1'b0, 4'hB, 4'b0000, 4'd2);
         if (s < 2) cyc();
      end
      cyc();
      fifo_full = 1'b0;
      #1;
      chk_all("stall_w2", 4'b0010, 1'b1, 1'b1, 4'hB, 4'b0010, 4'd2);
      cyc();
      chk_all("stall_w3", 4'b0010, 1'b1, 1'b1, 4'hB, 4'b0010, 4'd3);
      cyc();
      chk_all("stall_release", 4'b0000, 1'b0, 1'b0, 4'h0, 4'b0000, 4'd0);
      req = 4'b0000;

      // Early drop by requester 2 after one write
      req = 4'b0100;
      cyc();
      chk_all("drop_w0", 4'b0100, 1'b1, 1'b1, 4'hC, 4'b0100, 4'd0);
      cyc();
      req = 4'b0000;
      #1;
      chk_all("drop_low", 4'b0100, 1'b1, 1'b0, 4'hC, 4'b0000, 4'd1);
      cyc();
      chk_all("drop_idle", 4'b0000, 1'b0, 1'b0, 4'h0, 4'b0000, 4'd0);
      req = 4'b1001;      // scan resumes at 3, so 3 beats 0
      cyc();
      chk_all("drop_next", 4'b1000, 1'b1, 1'b1, 4'hD, 4'b1000, 4'd0);

      // Reset mid-burst at burst_cnt=2
      cyc();
      cyc();
      chk_all("mid_cnt2", 4'b1000, 1'b1, 1'b1, 4'hD, 4'b1000, 4'd2);
      rst_n = 1'b0;
      req   = 4'b1010;
      #1;
      chk_all("mid_reset", 4'b0000, 1'b0, 1'b0, 4'h0, 4'b0000, 4'd0);
      cyc();
      chk_all("mid_reset_hold", 4'b0000, 1'b0, 1'b0, 4'h0, 4'b0000, 4'd0);
      rst_n = 1'b1;
      cyc();
      chk_all("post_reset_grant", 4'b0010, 1'b1, 1'b1, 4'hB, 4'b0010, 4'd0);
      req = 4'b0000;
      cyc();
      chk_all("final_idle", 4'b0000, 1'b0, 1'b0, 4'h0, 4'b0000, 4'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the FIFO write port.
REQ-002 Parameter DATA_WIDTH, default 4: FIFO word width.
REQ-003 Parameter MAX_BURST, default 4: maximum words written per grant; legal range 1..15.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  NUM_REQ  per-requester write request; held high while the requester has data.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 fifo_full  input  1  FIFO full flag, already in the clk domain.
REQ-009 fifo_winc  output  1  FIFO write enable.
REQ-010 fifo_wdata  output  DATA_WIDTH  FIFO write data.
REQ-011 grant  output  NUM_REQ  registered one-hot owner of the write port; all zero when idle.
REQ-012 ack  output  NUM_REQ  one-hot pulse: the owner's word was written this cycle.
REQ-013 busy  output  1  high in BURST state.
REQ-014 burst_cnt  output  4  words written in the current grant.

Function
REQ-015 Two states: IDLE and BURST.
REQ-016 IDLE: if any req bit is high, select the first requester with req high, scanning round-robin from last_owner+1 with wrap-around; load the one-hot grant; clear burst_cnt; enter BURST next cycle.
REQ-017 IDLE with req all zero: remain in IDLE; grant stays all zero.
REQ-018 In BURST, fifo_winc is combinational and equals req[owner] AND NOT fifo_full.
REQ-019 fifo_wdata equals the owner's req_data slice in BURST, and zero in IDLE.
REQ-020 ack[owner] equals fifo_winc; all other ack bits are zero.
REQ-021 Each cycle with fifo_winc high increments burst_cnt by 1.
REQ-022 BURST ends, returning to IDLE next cycle, when either:
- a write occurs with burst_cnt = MAX_BURST-1; or
- req[owner] is low.
On ending, grant clears, last_owner takes the owner index, and burst_cnt clears.
REQ-023 fifo_full high in BURST stalls the burst: no write, no count change, grant held, no timeout.
REQ-024 Latency: req rising in IDLE at cycle N gives grant at N+1; the first write is at N+1 if fifo_full is low.
REQ-025 One idle bubble cycle separates consecutive grants.
REQ-026 Requests from non-owners during BURST are ignored until the next IDLE arbitration.
REQ-027 Under continuous requests from all requesters, no requester waits more than NUM_REQ-1 grants.
REQ-028 At most one grant bit and at most one ack bit are high in any cycle.

Reset
REQ-029 rst_n low asynchronously forces:
- state to IDLE;
- grant, burst_cnt and busy to 0;
- last_owner to NUM_REQ-1, so requester 0 wins first.
REQ-030 While rst_n is low, fifo_winc, fifo_wdata and ack are 0.
REQ-031 Reset during BURST aborts the burst immediately, with no write in the reset cycle.
REQ-032 The first arbitration occurs on the first rising edge after rst_n deasserts.

Verification
REQ-033 Single requester: req=0001, data 0xA, fifo_full=0, MAX_BURST=4 -> grant 0001 one cycle later, then four fifo_winc pulses with data 0xA, one IDLE cycle, then a new grant 0001.
REQ-034 Round robin: req=1111 held -> grants in order 0001, 0010, 0100, 1000, 0001, each 4 writes followed by a one-cycle bubble.
REQ-035 Full stall: grant 0010, after 2 writes fifo_full=1 for 3 cycles -> no winc and burst_cnt held at 2 during the stall; 2 more writes follow, then release.
REQ-036 Early drop: owner 0100 drops req after 1 write -> IDLE next cycle, burst_cnt cleared, next arbitration starts at requester 3.
REQ-037 Reset mid-burst: rst_n low at burst_cnt=2 -> grant, winc and busy go 0 immediately; after release with req=1010 the first grant is 0010.
REQ-038 Invariant check every cycle: grant and ack at most one-hot, and fifo_winc never high while fifo_full is high.
